vend_credit_seq: RTL and testbench

- Sequential credit controller for the vending datapath.
- Accepts coin, selection and cancel requests, and holds the running credit register.
- Sequences add and subtract operations through the downstream 4-bit combinational arithmetic unit (op 2'b00 add, 2'b01 subtract, other codes give result 0; 5-bit result), then commits or rejects the unit's result.
- Produces vend, change and reject pulses for the dispense/display stages.

---
 rtl/vend_credit_seq.sv | 207 ++++++++++++++++++++
 tb/tb_vend_credit_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_seq.sv
// ---------------------------------------------------------------------------
// vend_credit_seq
//
// Sequential credit controller for the vending datapath. It holds the running
// credit, takes coin / selection / cancel requests while idle, and runs each
// add or subtract through an external 4-bit arithmetic unit. The unit's
// result is then committed to credit or rejected. Vend, change and reject
// events leave the block as one-cycle registered pulses.
//
// Parameters
//   MAX_CREDIT   highest legal credit value (1..15)
//   AUTO_CHANGE  1: a successful vend is followed by return of the remaining
//                credit; 0: the remaining credit is kept
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   coin_valid/value    coin request and amount (sampled in IDLE only)
//   sel_valid/price     product selection request and price (IDLE only)
//   cancel              return-all-credit request (IDLE only)
//   alu_a/alu_b/alu_op  operands and op code to the arithmetic unit
//                       (combinational from state and registers)
//   alu_result          5-bit unit result, returned in the same cycle
//   credit              current credit (registered)
//   busy                high whenever the FSM is not in IDLE
//   vend                pulse: purchase committed
//   change_valid        pulse: change_amt carries the returned amount
//   change_amt          last returned amount, held between pulses
//   coin_reject         pulse: coin refused because credit would overflow
//   insufficient        pulse: selection refused, credit below price
//   req_dropped         pulse: a request was seen while busy
//
// Request handshake: there is no ready signal; busy acts as its inverse.
// A request (coin_valid, sel_valid or cancel) is taken in the same cycle
// it is high while busy is low, and is never held or queued. Only one
// request is taken per cycle, in priority cancel > sel_valid > coin_valid;
// the lower-priority ones are silently discarded. A request that is high
// while busy is high is discarded and reported with req_dropped.
// ---------------------------------------------------------------------------
module vend_credit_seq #(
    parameter int unsigned MAX_CREDIT  = 15,
    parameter bit          AUTO_CHANGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic       sel_valid,
    input  logic [3:0] sel_price,
    input  logic       cancel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [4:0] alu_result,
    output logic [3:0] credit,
    output logic       busy,
    output logic       vend,
    output logic       change_valid,
    output logic [3:0] change_amt,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       req_dropped
);

    // Arithmetic unit op codes. Any code other than add/sub yields 0, so
    // OP_NONE is driven whenever no arithmetic is wanted.
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NONE = 2'b11;

    // Overflow is judged on the full 5-bit result so a carry out of the
    // 4-bit sum counts as exceeding the limit.
    localparam logic [4:0] MAX_CREDIT_5 = 5'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_SUB    = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t     state_q,        state_d;
    logic [3:0] credit_q,       credit_d;
    logic [3:0] operand_q,      operand_d;
    logic [3:0] change_amt_q,   change_amt_d;
    logic       vend_q,         vend_d;
    logic       change_valid_q, change_valid_d;
    logic       coin_reject_q,  coin_reject_d;
    logic       insufficient_q, insufficient_d;
    logic       req_dropped_q,  req_dropped_d;

    logic       any_req;

    assign any_req = coin_valid | sel_valid | cancel;

    // -----------------------------------------------------------------------
    // State register. Reset wins over everything, so a reset during ADD,
    // SUB or RETURN abandons the operation without a commit or a pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= 4'd0;
            operand_q      <= 4'd0;
            change_amt_q   <= 4'd0;
            vend_q         <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            req_dropped_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            operand_q      <= operand_d;
            change_amt_q   <= change_amt_d;
            vend_q         <= vend_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            req_dropped_q  <= req_dropped_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, datapath and arithmetic-unit drive.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        operand_d      = operand_q;
        change_amt_d   = change_amt_q;
        vend_d         = 1'b0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        alu_a          = credit_q;
        alu_b          = 4'd0;
        alu_op         = OP_NONE;

        // Every non-IDLE state lasts a single cycle, so any request seen
        // outside IDLE is simply lost; report it.
        req_dropped_d  = (state_q != ST_IDLE) && any_req;

        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    state_d = ST_RETURN;
                end else if (sel_valid) begin
                    operand_d = sel_price;
                    state_d   = ST_SUB;
                end else if (coin_valid) begin
                    operand_d = coin_value;
                    state_d   = ST_ADD;
                end
            end

            ST_ADD: begin
                alu_b  = operand_q;
                alu_op = OP_ADD;
                if (alu_result > MAX_CREDIT_5) begin
                    coin_reject_d = 1'b1;
                end else begin
                    credit_d = alu_result[3:0];
                end
                state_d = ST_IDLE;
            end

            ST_SUB: begin
                alu_b  = operand_q;
                alu_op = OP_SUB;
                if (alu_result[4]) begin
                    // Borrow out: the price is above the credit.
                    insufficient_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    credit_d = alu_result[3:0];
                    vend_d   = 1'b1;
                    state_d  = AUTO_CHANGE ? ST_RETURN : ST_IDLE;
                end
            end

            ST_RETURN: begin
                // Nothing to hand back when credit is already zero, so no
                // change pulse is raised in that case.
                if (credit_q != 4'd0) begin
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = 4'd0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign credit       = credit_q;
    assign busy         = (state_q != ST_IDLE);
    assign vend         = vend_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;
    assign req_dropped  = req_dropped_q;

endmodule

// File: tb/tb_vend_credit_seq.sv
// Directed bench for vend_credit_seq. Two instances are used: dut_a with
// MAX_CREDIT=15 / AUTO_CHANGE=1 and dut_b with MAX_CREDIT=13 / AUTO_CHANGE=0.
// Each has its own arithmetic-unit model and its own request inputs.
module tb_vend_credit_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A signals
  logic       a_coin_valid, a_sel_valid, a_cancel;
  logic [3:0] a_coin_value, a_sel_price;
  logic [3:0] a_alu_a, a_alu_b, a_credit, a_change_amt;
  logic [1:0] a_alu_op;
  logic [4:0] a_alu_result;
  logic       a_busy, a_vend, a_change_valid, a_coin_reject, a_insufficient, a_req_dropped;

  // instance B signals
  logic       b_coin_valid, b_sel_valid, b_cancel;
  logic [3:0] b_coin_value, b_sel_price;
  logic [3:0] b_alu_a, b_alu_b, b_credit, b_change_amt;
  logic [1:0] b_alu_op;
  logic [4:0] b_alu_result;
  logic       b_busy, b_vend, b_change_valid, b_coin_reject, b_insufficient, b_req_dropped;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [3:0]  exp_q[$];

  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      default: return 5'd0;
    endcase
  endfunction

  assign a_alu_result = alu_model(a_alu_a, a_alu_b, a_alu_op);
  assign b_alu_result = alu_model(b_alu_a, b_alu_b, b_alu_op);

  vend_credit_seq #(.MAX_CREDIT(15), .AUTO_CHANGE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(a_coin_valid), .coin_value(a_coin_value),
    .sel_valid(a_sel_valid), .sel_price(a_sel_price), .cancel(a_cancel),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_op(a_alu_op), .alu_result(a_alu_result),
    .credit(a_credit), .busy(a_busy), .vend(a_vend),
    .change_valid(a_change_valid), .change_amt(a_change_amt),
    .coin_reject(a_coin_reject), .insufficient(a_insufficient), .req_dropped(a_req_dropped)
  );

  vend_credit_seq #(.MAX_CREDIT(13), .AUTO_CHANGE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(b_coin_valid), .coin_value(b_coin_value),
    .sel_valid(b_sel_valid), .sel_price(b_sel_price), .cancel(b_cancel),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_op(b_alu_op), .alu_result(b_alu_result),
    .credit(b_credit), .busy(b_busy), .vend(b_vend),
    .change_valid(b_change_valid), .change_amt(b_change_amt),
    .coin_reject(b_coin_reject), .insufficient(b_insufficient), .req_dropped(b_req_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard for instance A change returns: every change_valid pulse must
  // match the next expected amount.
  always @(negedge clk) begin
    if (rst_n && a_change_valid) begin
      if (exp_q.size() == 0) chk("chg_unexpected", 1, 0);
      else                   chk("chg_amt_sb", a_change_amt, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit tgt_b, input logic cn, input logic sv, input logic [3:0] sp,
                       input logic cv, input logic [3:0] val);
    if (!tgt_b) begin
      a_cancel = cn; a_sel_valid = sv; a_sel_price = sp; a_coin_valid = cv; a_coin_value = val;
    end else begin
      b_cancel = cn; b_sel_valid = sv; b_sel_price = sp; b_coin_valid = cv; b_coin_value = val;
    end
  endtask

  task automatic idle(input bit tgt_b);
    drive(tgt_b, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  // Issue a one-cycle coin, then advance to just after edge N+1.
  task automatic coin(input bit tgt_b, input logic [3:0] v);
    drive(tgt_b, 1'b0, 1'b0, 4'd0, 1'b1, v);
    step();
    idle(tgt_b);
    step();
  endtask

  initial begin
    idle(1'b0);
    idle(1'b1);

    // ---- reset with coin_valid held high ----
    rst_n = 1'b0;
    a_coin_valid = 1'b1; a_coin_value = 4'd5;
    step(); step();
    chk("rst_credit", a_credit, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_vend", a_vend, 0);
    chk("rst_chg_valid", a_change_valid, 0);
    chk("rst_chg_amt", a_change_amt, 0);
    chk("rst_coin_rej", a_coin_reject, 0);
    chk("rst_insuff", a_insufficient, 0);
    chk("rst_dropped", a_req_dropped, 0);
    idle(1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", a_busy, 0);
    chk("idle_op", a_alu_op, 3);

    // ---- coin 5 then 7 ----
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    step();
    idle(1'b0);
    chk("add_busy", a_busy, 1);
    chk("add_op", a_alu_op, 0);
    chk("add_b", a_alu_b, 5);
    chk("add_credit_hold", a_credit, 0);
    step();
    chk("coin5_credit", a_credit, 5);
    chk("coin5_busy", a_busy, 0);
    step();
    coin(1'b0, 4'd7);
    chk("coin7_credit", a_credit, 12);
    chk("coin7_rej", a_coin_reject, 0);

    // ---- overflow: 12 + 5 = 17 ----
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    step();
    idle(1'b0);
    chk("ovf_result", a_alu_result, 17);
    step();
    chk("ovf_reject", a_coin_reject, 1);
    chk("ovf_credit", a_credit, 12);
    step();
    chk("ovf_pulse_end", a_coin_reject, 0);

    // ---- insufficient: price 13 with credit 12 ----
    drive(1'b0, 1'b0, 1'b1, 4'd13, 1'b0, 4'd0);
    step();
    idle(1'b0);
    chk("sub_op", a_alu_op, 1);
    step();
    chk("insuff_pulse", a_insufficient, 1);
    chk("insuff_vend", a_vend, 0);
    chk("insuff_credit", a_credit, 12);
    chk("insuff_busy", a_busy, 0);

    // ---- purchase price 9 with auto change ----
    exp_q.push_back(4'd3);
    drive(1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0);
    step();
    idle(1'b0);
    step();
    chk("vend_pulse", a_vend, 1);
    chk("vend_credit", a_credit, 3);
    chk("vend_busy_ret", a_busy, 1);
    step();
    chk("chg_valid", a_change_valid, 1);
    chk("chg_amt", a_change_amt, 3);
    chk("chg_credit", a_credit, 0);
    chk("vend_pulse_end", a_vend, 0);
    step();
    chk("chg_valid_end", a_change_valid, 0);
    chk("chg_amt_hold", a_change_amt, 3);

    // ---- priority: all three requests with credit 6 ----
    coin(1'b0, 4'd6);
    chk("coin6_credit", a_credit, 6);
    exp_q.push_back(4'd6);
    drive(1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 4'd3);
    step();
    idle(1'b0);
    chk("prio_busy", a_busy, 1);
    chk("prio_op", a_alu_op, 3);
    chk("prio_credit", a_credit, 6);
    chk("prio_no_drop", a_req_dropped, 0);
    step();
    chk("prio_chg_valid", a_change_valid, 1);
    chk("prio_chg_amt", a_change_amt, 6);
    chk("prio_credit0", a_credit, 0);
    chk("prio_no_drop2", a_req_dropped, 0);
    chk("prio_no_vend", a_vend, 0);

    // ---- coin while busy in ADD ----
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4);
    step();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd8);
    step();
    idle(1'b0);
    chk("drop_pulse", a_req_dropped, 1);
    chk("drop_credit", a_credit, 4);
    step();
    chk("drop_pulse_end", a_req_dropped, 0);
    chk("drop_credit2", a_credit, 4);
    chk("drop_idle", a_busy, 0);

    // ---- boundary: reach exactly 15, then buy at price == credit ----
    coin(1'b0, 4'd11);
    chk("max_credit", a_credit, 15);
    chk("max_no_rej", a_coin_reject, 0);
    drive(1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0);
    step();
    idle(1'b0);
    step();
    chk("exact_vend", a_vend, 1);
    chk("exact_credit", a_credit, 0);
    step();
    chk("zero_ret_no_chg", a_change_valid, 0);
    chk("zero_ret_amt_hold", a_change_amt, 6);
    chk("zero_ret_idle", a_busy, 0);

    // ---- instance B: MAX_CREDIT=13, AUTO_CHANGE=0 ----
    coin(1'b1, 4'd5);
    step();
    coin(1'b1, 4'd7);
    chk("b_credit12", b_credit, 12);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2);
    step();
    idle(1'b1);
    chk("b_ovf_result", b_alu_result, 14);
    step();
    chk("b_ovf_reject", b_coin_reject, 1);
    chk("b_ovf_credit", b_credit, 12);
    step();
    coin(1'b1, 4'd1);
    chk("b_max_credit", b_credit, 13);
    chk("b_max_no_rej", b_coin_reject, 0);
    drive(1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
    step();
    idle(1'b1);
    step();
    chk("b_vend", b_vend, 1);
    chk("b_vend_credit", b_credit, 9);
    chk("b_no_return", b_busy, 0);
    step();
    chk("b_no_chg", b_change_valid, 0);
    chk("b_credit_kept", b_credit, 9);

    // ---- mid-operation reset in SUB (instance A) ----
    coin(1'b0, 4'd10);
    chk("mid_credit10", a_credit, 10);
    drive(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
    step();
    idle(1'b0);
    chk("mid_in_sub", a_alu_op, 1);
    rst_n = 1'b0;
    step();
    chk("mid_no_vend", a_vend, 0);
    chk("mid_credit0", a_credit, 0);
    chk("mid_idle", a_busy, 0);
    chk("mid_no_chg", a_change_valid, 0);
    rst_n = 1'b1;
    step();
    chk("mid_stay_idle", a_busy, 0);
    chk("mid_no_vend2", a_vend, 0);

    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
